// File: rtl/comp_serial.sv
// Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per cycle, MSB digit first.
// Optional build macro COMP_EARLY_EXIT_EN: finish on the first differing digit.
module comp_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sgn_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]    IDX_LAST = IW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic             dec_gt_q, dec_lt_q;
    logic             busy_q, done_q, gt_q, lt_q, eq_q;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic             decided;
    logic             dec_gt_d, dec_lt_d;
    logic             finish_d;

    // Operands shift left each RUN edge, so the digit under test is always the top one.
    always_comb begin
        dig_a    = a_q[WIDTH-1 -: DIGIT];
        dig_b    = b_q[WIDTH-1 -: DIGIT];
        decided  = dec_gt_q | dec_lt_q;
        dec_gt_d = dec_gt_q | (!decided && (dig_a > dig_b));
        dec_lt_d = dec_lt_q | (!decided && (dig_a < dig_b));
`ifdef COMP_EARLY_EXIT_EN
        finish_d = (idx_q == '0) || dec_gt_d || dec_lt_d;
`else
        finish_d = (idx_q == '0);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            dec_gt_q <= 1'b0;
            dec_lt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order.
                        a_q      <= a_i ^ (sgn_i ? MSB_MASK : '0);
                        b_q      <= b_i ^ (sgn_i ? MSB_MASK : '0);
                        idx_q    <= IDX_LAST;
                        dec_gt_q <= 1'b0;
                        dec_lt_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q      <= a_q << DIGIT;
                    b_q      <= b_q << DIGIT;
                    idx_q    <= idx_q - 1'b1;
                    dec_gt_q <= dec_gt_d;
                    dec_lt_q <= dec_lt_d;
                    if (finish_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        gt_q    <= dec_gt_d;
                        lt_q    <= dec_lt_d;
                        eq_q    <= !(dec_gt_d || dec_lt_d);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign gt_o   = gt_q;
    assign lt_o   = lt_q;
    assign eq_o   = eq_q;

endmodule

// File: doc/comp_serial.md
# comp_serial

Parametrised, multi-cycle magnitude comparator that generalises the single-bit compare cell to WIDTH-bit operands. Operands are processed DIGIT bits per cycle, MSB digit first, with a start/busy/done handshake and an unsigned or two's-complement mode. It sits beside the FIFO control path for occupancy and threshold compares where a wide single-cycle comparator would limit timing.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle, 1..WIDTH; NDIG = WIDTH/DIGIT.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- sgn  in  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results valid.
- gt  out  1  A > B.
- lt  out  1  A < B.
- eq  out  1  A == B.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b and sgn, clear the internal decision, set the digit index to NDIG-1 (MSB digit), and go to RUN.
- Signed mode: invert bit WIDTH-1 of both latched operands, then compare as unsigned.
- RUN: each edge compares the current digit pair as unsigned values.
  - If no decision has been made yet and the digits differ, record gt or lt.
  - Once a decision is recorded, later digits do not change it.
  - The index decrements each edge. After the last digit (index 0), go to DONE.
- DONE: load gt, lt and eq from the decision (eq=1 if no digit differed) and pulse done. Go to IDLE on the next edge.
- Exactly one of gt, lt and eq is 1 after the first done. The values hold until the next done.
- start is ignored in RUN and in DONE; it is not queued.
- Operand inputs are don't-care outside the accepting edge.
- DIGIT=1 reduces to one single-bit compare cell per cycle.

## Timing
- Reset: state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0. These values are visible after the reset edge.
- Edge 0 is the edge that accepts start. busy=1 after edge 0.
- Digits are processed on edges 1..NDIG.
- After edge NDIG: done=1, results valid, busy=0.
- After edge NDIG+1: IDLE, done=0.
- Earliest next accept is edge NDIG+2, so throughput is one compare per NDIG+2 cycles.
- rst during RUN or DONE aborts the operation: no done pulse, and the outputs take their reset values.
- rst has priority over start in the same cycle.

## Configuration
- COMP_EARLY_EXIT_EN defined:
  - In RUN, the first differing digit (k = 0 for the MSB digit) moves the FSM to DONE on that same edge.
  - done is then high after edge k+1.
  - Equal operands still take NDIG edges.
- COMP_EARLY_EXIT_EN undefined: latency is always NDIG edges, independent of the data.
- Result values are identical in both builds.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Reset: hold rst with start=1 for 3 cycles -> busy=0, done=0, gt=lt=eq=0; no operation starts.
- Equal operands: a=0x1234, b=0x1234, sgn=0 -> done after edge 4 in both builds, eq=1, gt=lt=0, done high for exactly 1 cycle.
- Sign mode: a=0x8000, b=0x7FFF.
  - sgn=0 -> gt=1.
  - Repeat with sgn=1 -> lt=1.
  - a=0xFFFF, b=0x0001, sgn=1 -> lt=1.
- Early exit: a=0xA000, b=0x5FFF, sgn=0 -> gt=1.
  - With COMP_EARLY_EXIT_EN: done after edge 1.
  - Without it: done after edge 4.
  - a=0x1230, b=0x1231 -> lt=1, done after edge 4 in both builds.
- Handshake: hold start=1 continuously with changing operands -> operands are accepted only on edges 0, 6, 12, ...; changes during RUN/DONE do not affect results.
- Mid-operation reset: start at edge 0, rst=1 sampled at edge 2 -> busy=0 after edge 2, no done pulse, outputs 0; a new start at edge 3 completes normally.
